id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised, registered instruction-decode stage for the in-order pipeline. It decodes R-type, lw, sw and beqz instructions and captures operands and control bits into an ID/EX pipeline register. It detects load-use hazards and inserts bubbles, resolves branches in ID, and honours an external flush. It sits between the IF stage / register file and the EX stage, and replaces the earlier purely combinational decoder.

## Interface
- DATA_W, 32, datapath and PC width (>= 16).
- REG_AW, 5, register address width; address fields are taken from the standard instruction bit positions, zero-extended or truncated to REG_AW.
- ZERO_CMP, 1, branch compare mode: 1 = taken when rs_data == 0; 0 = taken when rs_data == rt_data.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction from IF is valid.
- instruction  in  32  instruction word.
- pc  in  DATA_W  PC of the instruction.
- rs_data, rt_data  in  DATA_W  register-file read data (combinational).
- flush_in  in  1  squash the instruction currently in ID.
- rs, rt  out  REG_AW  combinational register-file read addresses, instruction[25:21] and [20:16].
- stall_out  out  1  combinational; IF must hold pc and instruction.
- branch_taken  out  1  combinational redirect request.
- branch_target  out  DATA_W  combinational redirect target.
- ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_illegal  out  1 each  registered.
- ex_opcode  out  6  registered.
- ex_rd  out  REG_AW  registered.
- ex_imm, ex_rs_data, ex_rt_data  out  DATA_W  registered.
- stall_count  out  CNT_W  registered.

## Operation
- Decode:
  - R-type (000000): rd = instruction[15:11]; reg_write = 1.
  - lw (100011): rd = rt; imm = sign-extended imm16; mem_read = 1; reg_write = 1.
  - sw (101011): imm = sign-extended imm16; ex_rt_data carries the store data; mem_write = 1.
  - beqz (000100): branch only; no register-file or memory side effect.
  - Any other opcode: ex_illegal = 1; all other controls 0.
- reg_write is forced to 0 when the destination register is 0.
- Operand usage:
  - uses_rs: R-type, lw, sw, beqz.
  - uses_rt: R-type, sw, and beqz when ZERO_CMP = 0.
- Hazard condition: in_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((uses_rs & ex_rd == rs) | (uses_rt & ex_rd == rt)).
- Hazard response:
  - stall_out = 1.
  - The ID/EX register loads a bubble: ex_valid = 0, all controls 0, data 0.
  - branch_taken is suppressed.
- Branch, when in_valid and the instruction is beqz with no hazard and no flush:
  - branch_taken = compare result.
  - branch_target = pc + 4 + (imm_ext << 2), truncated to DATA_W (wraps modulo 2^DATA_W).
- Flush: flush_in = 1 loads a bubble, forces stall_out = 0 and branch_taken = 0, and overrides a simultaneous hazard.
- A beqz that is not flushed enters ID/EX as a valid no-op (ex_valid = 1, controls 0).
- stall_count increments on every cycle with stall_out = 1 and saturates at all-ones.

## Timing
- Decode-to-ID/EX latency is 1 cycle: outputs reflect the instruction present on the preceding edge.
- A load-use hazard costs exactly one bubble. On the next cycle ex_valid = 0, so the hazard clears and the held instruction issues.
- branch_taken and branch_target are valid in the same cycle as the instruction. IF squashes its own fetch.
- in_valid = 0 loads a bubble; stall_out = 0.
- Reset (asynchronous, mid-operation included):
  - All ex_* outputs and stall_count go to 0 immediately.
  - Combinational outputs follow inputs, with the hazard term forced 0 because ex_valid = 0.
- Release of reset is synchronous to clk; the first edge after release captures normally.

## Test plan
- Reset mid-stream: assert reset low between edges while ex_valid = 1 -> all ex_* outputs and stall_count are 0 before the next edge.
- lw 0x8C220008 (rs=1, rt=2, imm=8) -> next cycle ex_mem_read=1, ex_reg_write=1, ex_rd=2, ex_imm=0x00000008, ex_rs_data equals the rs_data value presented.
- Load-use:
  - Stimulus: lw 0x8C220008, then add 0x00441800 (rs=2, rt=4, rd=3).
  - Required: stall_out=1 for exactly one cycle; one bubble (ex_valid=0); add then issues with ex_rd=3; stall_count=1.
- Branch, ZERO_CMP=1:
  - Stimulus: beqz 0x10A0FFFE, pc=0x100, rs_data=0.
  - Required: branch_taken=1, branch_target=0x000000FC.
  - Repeat with rs_data=7: branch_taken=0.
- Flush with hazard: lw r2, then add using r2 with flush_in=1 -> stall_out=0, bubble loaded, stall_count unchanged.
- Edge cases:
  - R-type with rd=0 -> ex_reg_write=0.
  - opcode 111111 -> ex_illegal=1, ex_valid=1, other controls 0.
  - DATA_W=16 build, pc=0xFFFC, imm=+1 -> branch_target=0x0004.

Source files
------------

// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
//   Registered instruction-decode stage. It decodes R-type, lw, sw and beqz,
//   captures operands and control bits into the ID/EX register, inserts a
//   single bubble on a load-use hazard, resolves beqz in ID and honours a flush.
//
//   Ports
//     clk, reset             clock, asynchronous active-low reset
//     in_valid, instruction  instruction from IF (held by IF while stall_out)
//     pc                     PC of the instruction in ID
//     rs_data, rt_data       combinational register-file read data
//     flush_in               squash the instruction currently in ID
//     rs, rt                 register-file read addresses (combinational)
//     stall_out              IF must hold pc/instruction (combinational)
//     branch_taken/_target   redirect request and target (combinational)
//     ex_*                   ID/EX pipeline register contents
//     stall_count            saturating count of stall cycles
//
//   Data capture: ex_rs_data/ex_rt_data carry the read data only for the
//   operands the instruction uses (0 otherwise); ex_imm carries the
//   sign-extended immediate for lw/sw (0 otherwise); ex_opcode carries the
//   opcode of every issued instruction, illegal ones included.
// -----------------------------------------------------------------------------
module id_stage_pipe #(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 5,
   parameter int ZERO_CMP = 1,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [31:0]       instruction,
   input  logic [DATA_W-1:0] pc,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic              flush_in,
   output logic [REG_AW-1:0] rs,
   output logic [REG_AW-1:0] rt,
   output logic              stall_out,
   output logic              branch_taken,
   output logic [DATA_W-1:0] branch_target,
   output logic              ex_valid,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_reg_write,
   output logic              ex_illegal,
   output logic [5:0]        ex_opcode,
   output logic [REG_AW-1:0] ex_rd,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQZ  = 6'b000100;

   typedef struct packed {
      logic              valid;
      logic              mem_read;
      logic              mem_write;
      logic              reg_write;
      logic              illegal;
      logic [5:0]        opcode;
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] rs_val;
      logic [DATA_W-1:0] rt_val;
   } ex_reg_t;

   ex_reg_t           r_ex;
   ex_reg_t           w_ex_nxt;
   logic [CNT_W-1:0]  r_stall_count;

   logic [5:0]        w_opcode;
   logic [REG_AW-1:0] w_rs;
   logic [REG_AW-1:0] w_rt;
   logic [REG_AW-1:0] w_rd_r;
   logic [DATA_W-1:0] w_imm_ext;
   logic              w_is_rtype;
   logic              w_is_lw;
   logic              w_is_sw;
   logic              w_is_beqz;
   logic              w_uses_rs;
   logic              w_uses_rt;
   logic              w_hazard;
   logic              w_issue;
   logic              w_cmp;

   // Field extraction; register fields are zero-extended or truncated to REG_AW.
   assign w_opcode  = instruction[31:26];
   assign w_rs      = REG_AW'(instruction[25:21]);
   assign w_rt      = REG_AW'(instruction[20:16]);
   assign w_rd_r    = REG_AW'(instruction[15:11]);
   assign w_imm_ext = DATA_W'($signed(instruction[15:0]));

   assign w_is_rtype = (w_opcode == OP_RTYPE);
   assign w_is_lw    = (w_opcode == OP_LW);
   assign w_is_sw    = (w_opcode == OP_SW);
   assign w_is_beqz  = (w_opcode == OP_BEQZ);

   assign w_uses_rs = w_is_rtype | w_is_lw | w_is_sw | w_is_beqz;
   assign w_uses_rt = w_is_rtype | w_is_sw | (w_is_beqz & (ZERO_CMP == 0));

   // Load-use: the load in EX has not produced its data yet. After reset
   // r_ex.valid is 0, so the term is inactive until something issues.
   assign w_hazard = in_valid & r_ex.valid & r_ex.mem_read & (r_ex.rd != '0) &
                     ((w_uses_rs & (r_ex.rd == w_rs)) |
                      (w_uses_rt & (r_ex.rd == w_rt)));

   // Flush overrides the hazard: a squashed instruction must not hold IF.
   assign stall_out = w_hazard & ~flush_in;
   assign w_issue   = in_valid & ~flush_in & ~w_hazard;

   assign w_cmp         = (ZERO_CMP != 0) ? (rs_data == '0) : (rs_data == rt_data);
   assign branch_taken  = w_issue & w_is_beqz & w_cmp;
   assign branch_target = pc + DATA_W'(4) + (w_imm_ext << 2);

   assign rs = w_rs;
   assign rt = w_rt;

   always_comb begin
      // NOTE: every field gets a default before any branch, so no path can
      // leave a bit unassigned and infer a latch; the default is the bubble.
      w_ex_nxt = '0;
      if (w_issue) begin
         w_ex_nxt.valid  = 1'b1;
         w_ex_nxt.opcode = w_opcode;
         w_ex_nxt.rs_val = w_uses_rs ? rs_data : '0;
         w_ex_nxt.rt_val = w_uses_rt ? rt_data : '0;
         if (w_is_rtype) begin
            w_ex_nxt.rd        = w_rd_r;
            w_ex_nxt.reg_write = (w_rd_r != '0);
         end else if (w_is_lw) begin
            w_ex_nxt.rd        = w_rt;
            w_ex_nxt.imm       = w_imm_ext;
            w_ex_nxt.mem_read  = 1'b1;
            w_ex_nxt.reg_write = (w_rt != '0);
         end else if (w_is_sw) begin
            w_ex_nxt.imm       = w_imm_ext;
            w_ex_nxt.mem_write = 1'b1;
         end else if (!w_is_beqz) begin
            // beqz issues as a valid no-op; anything else is illegal.
            w_ex_nxt.illegal   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ex          <= '0;
         r_stall_count <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every
         // register samples the pre-edge values of the others.
         r_ex <= w_ex_nxt;
         if (stall_out && (r_stall_count != '1))
            r_stall_count <= r_stall_count + CNT_W'(1);
      end
   end

   assign ex_valid     = r_ex.valid;
   assign ex_mem_read  = r_ex.mem_read;
   assign ex_mem_write = r_ex.mem_write;
   assign ex_reg_write = r_ex.reg_write;
   assign ex_illegal   = r_ex.illegal;
   assign ex_opcode    = r_ex.opcode;
   assign ex_rd        = r_ex.rd;
   assign ex_imm       = r_ex.imm;
   assign ex_rs_data   = r_ex.rs_val;
   assign ex_rt_data   = r_ex.rt_val;
   assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_id_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipe
//   Drives two builds of id_stage_pipe with the same instruction stream:
//     dut_a: DATA_W=32, ZERO_CMP=1, CNT_W=16
//     dut_b: DATA_W=16, ZERO_CMP=0, CNT_W=2 (stall counter saturates quickly)
//   A behavioural model predicts combinational outputs and the next ID/EX
//   contents for each cycle. Directed cases come first, then random traffic.
// -----------------------------------------------------------------------------
module tb_id_stage_pipe;

   typedef struct packed {
      logic        valid;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic        illegal;
      logic [5:0]  opcode;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [31:0] rsd;
      logic [31:0] rtd;
   } ex_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] instruction;
   logic        flush_in;
   logic [31:0] pc_a, rsd_a, rtd_a;
   logic [15:0] pc_b, rsd_b, rtd_b;

   logic [4:0]  a_rs, a_rt, a_ex_rd, b_rs, b_rt, b_ex_rd;
   logic        a_stall, a_bt, b_stall, b_bt;
   logic [31:0] a_tgt, a_ex_imm, a_ex_rs_data, a_ex_rt_data;
   logic [15:0] b_tgt, b_ex_imm, b_ex_rs_data, b_ex_rt_data;
   logic        a_ex_valid, a_ex_mem_read, a_ex_mem_write, a_ex_reg_write, a_ex_illegal;
   logic        b_ex_valid, b_ex_mem_read, b_ex_mem_write, b_ex_reg_write, b_ex_illegal;
   logic [5:0]  a_ex_opcode, b_ex_opcode;
   logic [15:0] a_stall_count;
   logic [1:0]  b_stall_count;

   int n_checks = 0;
   int n_fail   = 0;

   ex_t         m_a, m_b;
   int          cnt_a, cnt_b;
   logic        obs_stall_a, obs_bt_a, obs_stall_b, obs_bt_b;
   logic [31:0] obs_tgt_a;
   logic [15:0] obs_tgt_b;
   bit          last_stall;

   always #5 clk = ~clk;

   id_stage_pipe #(.DATA_W(32), .REG_AW(5), .ZERO_CMP(1), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction),
      .pc(pc_a), .rs_data(rsd_a), .rt_data(rtd_a), .flush_in(flush_in),
      .rs(a_rs), .rt(a_rt), .stall_out(a_stall), .branch_taken(a_bt),
      .branch_target(a_tgt), .ex_valid(a_ex_valid), .ex_mem_read(a_ex_mem_read),
      .ex_mem_write(a_ex_mem_write), .ex_reg_write(a_ex_reg_write),
      .ex_illegal(a_ex_illegal), .ex_opcode(a_ex_opcode), .ex_rd(a_ex_rd),
      .ex_imm(a_ex_imm), .ex_rs_data(a_ex_rs_data), .ex_rt_data(a_ex_rt_data),
      .stall_count(a_stall_count)
   );

   id_stage_pipe #(.DATA_W(16), .REG_AW(5), .ZERO_CMP(0), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction),
      .pc(pc_b), .rs_data(rsd_b), .rt_data(rtd_b), .flush_in(flush_in),
      .rs(b_rs), .rt(b_rt), .stall_out(b_stall), .branch_taken(b_bt),
      .branch_target(b_tgt), .ex_valid(b_ex_valid), .ex_mem_read(b_ex_mem_read),
      .ex_mem_write(b_ex_mem_write), .ex_reg_write(b_ex_reg_write),
      .ex_illegal(b_ex_illegal), .ex_opcode(b_ex_opcode), .ex_rd(b_ex_rd),
      .ex_imm(b_ex_imm), .ex_rs_data(b_ex_rs_data), .ex_rt_data(b_ex_rt_data),
      .stall_count(b_stall_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference behaviour for one ID cycle, computed from the decode rules.
   function automatic void model(input int dw, input bit zc, input ex_t ex,
                                 input bit v, input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] rsd_i, input logic [31:0] rtd_i,
                                 input bit fl, output bit stall, output bit bt,
                                 output logic [31:0] tgt, output ex_t nxt);
      logic [31:0] mask, imm, rsd, rtd;
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd;
      bit          is_r, is_lw, is_sw, is_bq, u_rs, u_rt, haz, cmp;
      mask  = (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
      op    = ins[31:26];
      rs    = ins[25:21];
      rt    = ins[20:16];
      rd    = ins[15:11];
      imm   = {{16{ins[15]}}, ins[15:0]} & mask;
      rsd   = rsd_i & mask;
      rtd   = rtd_i & mask;
      is_r  = (op == 6'd0);
      is_lw = (op == 6'd35);
      is_sw = (op == 6'd43);
      is_bq = (op == 6'd4);
      u_rs  = is_r || is_lw || is_sw || is_bq;
      u_rt  = is_r || is_sw || (is_bq && !zc);
      haz   = v && ex.valid && ex.mem_read && (ex.rd != 0) &&
              ((u_rs && ex.rd == rs) || (u_rt && ex.rd == rt));
      cmp   = zc ? (rsd == 0) : (rsd == rtd);
      stall = haz && !fl;
      bt    = v && is_bq && !haz && !fl && cmp;
      tgt   = (pc + 32'd4 + (imm << 2)) & mask;
      nxt   = '0;
      if (v && !fl && !haz) begin
         nxt.valid  = 1'b1;
         nxt.opcode = op;
         nxt.rsd    = u_rs ? rsd : 32'd0;
         nxt.rtd    = u_rt ? rtd : 32'd0;
         if (is_r) begin
            nxt.rd = rd; nxt.reg_write = (rd != 0);
         end else if (is_lw) begin
            nxt.rd = rt; nxt.imm = imm; nxt.mem_read = 1'b1; nxt.reg_write = (rt != 0);
         end else if (is_sw) begin
            nxt.imm = imm; nxt.mem_write = 1'b1;
         end else if (!is_bq) begin
            nxt.illegal = 1'b1;
         end
      end
   endfunction

   task automatic check_regs();
      check("a.ex_valid",     a_ex_valid,     m_a.valid);
      check("a.ex_mem_read",  a_ex_mem_read,  m_a.mem_read);
      check("a.ex_mem_write", a_ex_mem_write, m_a.mem_write);
      check("a.ex_reg_write", a_ex_reg_write, m_a.reg_write);
      check("a.ex_illegal",   a_ex_illegal,   m_a.illegal);
      check("a.ex_opcode",    a_ex_opcode,    m_a.opcode);
      check("a.ex_rd",        a_ex_rd,        m_a.rd);
      check("a.ex_imm",       a_ex_imm,       m_a.imm);
      check("a.ex_rs_data",   a_ex_rs_data,   m_a.rsd);
      check("a.ex_rt_data",   a_ex_rt_data,   m_a.rtd);
      check("a.stall_count",  a_stall_count,  cnt_a);
      check("b.ex_valid",     b_ex_valid,     m_b.valid);
      check("b.ex_mem_read",  b_ex_mem_read,  m_b.mem_read);
      check("b.ex_mem_write", b_ex_mem_write, m_b.mem_write);
      check("b.ex_reg_write", b_ex_reg_write, m_b.reg_write);
      check("b.ex_illegal",   b_ex_illegal,   m_b.illegal);
      check("b.ex_opcode",    b_ex_opcode,    m_b.opcode);
      check("b.ex_rd",        b_ex_rd,        m_b.rd);
      check("b.ex_imm",       b_ex_imm,       m_b.imm);
      check("b.ex_rs_data",   b_ex_rs_data,   m_b.rsd);
      check("b.ex_rt_data",   b_ex_rt_data,   m_b.rtd);
      check("b.stall_count",  b_stall_count,  cnt_b);
   endtask

   // One ID cycle: drive, check combinational outputs mid-cycle, clock,
   // then check the ID/EX register against the model.
   task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] rs_d, input logic [31:0] rt_d, input bit fl);
      bit          s_a, s_b, bt_a, bt_b;
      logic [31:0] t_a, t_b;
      ex_t         n_a, n_b;
      in_valid = v; instruction = ins; flush_in = fl;
      pc_a = pc; rsd_a = rs_d; rtd_a = rt_d;
      pc_b = pc[15:0]; rsd_b = rs_d[15:0]; rtd_b = rt_d[15:0];
      #4;
      model(32, 1'b1, m_a, v, ins, pc, rs_d, rt_d, fl, s_a, bt_a, t_a, n_a);
      model(16, 1'b0, m_b, v, ins, pc, rs_d, rt_d, fl, s_b, bt_b, t_b, n_b);
      check("a.rs", a_rs, ins[25:21]);
      check("a.rt", a_rt, ins[20:16]);
      check("b.rs", b_rs, ins[25:21]);
      check("b.rt", b_rt, ins[20:16]);
      check("a.stall_out", a_stall, s_a);
      check("b.stall_out", b_stall, s_b);
      check("a.branch_taken", a_bt, bt_a);
      check("b.branch_taken", b_bt, bt_b);
      if (v && ins[31:26] == 6'd4) begin
         check("a.branch_target", a_tgt, t_a);
         check("b.branch_target", b_tgt, t_b);
      end
      obs_stall_a = a_stall; obs_bt_a = a_bt; obs_tgt_a = a_tgt;
      obs_stall_b = b_stall; obs_bt_b = b_bt; obs_tgt_b = b_tgt;
      last_stall  = s_a || s_b;
      @(posedge clk);
      #1;
      m_a = n_a;
      m_b = n_b;
      if (s_a && cnt_a != 16'hFFFF) cnt_a++;
      if (s_b && cnt_b != 3) cnt_b++;
      check_regs();
   endtask

   // Asynchronous reset between edges, with a hazard-causing instruction on
   // the inputs; registered state must clear before the next edge.
   task automatic reset_mid(input logic [31:0] ins);
      in_valid = 1'b1; instruction = ins; flush_in = 1'b0;
      reset = 1'b0;
      m_a = '0; m_b = '0; cnt_a = 0; cnt_b = 0;
      #2;
      check_regs();
      check("rst.a.stall_out", a_stall, 1'b0);
      check("rst.b.stall_out", b_stall, 1'b0);
      reset = 1'b1;
      last_stall = 1'b0;
      #1;
   endtask

   initial begin
      logic [31:0] ins, pc, rs_d, rt_d, r;
      logic [5:0]  op;
      bit          v, fl;
      m_a = '0; m_b = '0; cnt_a = 0; cnt_b = 0; last_stall = 1'b0;
      reset = 1'b0; in_valid = 1'b0; instruction = '0; flush_in = 1'b0;
      pc_a = '0; rsd_a = '0; rtd_a = '0; pc_b = '0; rsd_b = '0; rtd_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check_regs();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // lw r2, 8(r1)
      step(1'b1, 32'h8C22_0008, 32'h40, 32'h1111_1111, 32'h2222_2222, 1'b0);
      check("lw.mem_read",  a_ex_mem_read,  1'b1);
      check("lw.reg_write", a_ex_reg_write, 1'b1);
      check("lw.rd",        a_ex_rd,        5'd2);
      check("lw.imm",       a_ex_imm,       32'h0000_0008);
      check("lw.rs_data",   a_ex_rs_data,   32'h1111_1111);

      // add r3, r2, r4 right behind the load: one stall, one bubble
      step(1'b1, 32'h0044_1800, 32'h44, 32'h5, 32'h6, 1'b0);
      check("lu.stall1", obs_stall_a, 1'b1);
      check("lu.bubble", a_ex_valid,  1'b0);
      step(1'b1, 32'h0044_1800, 32'h44, 32'h5, 32'h6, 1'b0);
      check("lu.stall2", obs_stall_a, 1'b0);
      check("lu.issue",  a_ex_valid,  1'b1);
      check("lu.rd",     a_ex_rd,     5'd3);
      check("lu.count",  a_stall_count, 16'd1);

      // beqz r5, -2 at pc 0x100
      step(1'b1, 32'h10A0_FFFE, 32'h100, 32'h0, 32'h9, 1'b0);
      check("bq.taken",  obs_bt_a,  1'b1);
      check("bq.target", obs_tgt_a, 32'h0000_00FC);
      check("bq.noop",   a_ex_valid, 1'b1);
      step(1'b1, 32'h10A0_FFFE, 32'h100, 32'h7, 32'h9, 1'b0);
      check("bq.not_taken", obs_bt_a, 1'b0);

      // flush overriding a load-use hazard
      step(1'b1, 32'h8C22_0008, 32'h48, 32'h1, 32'h2, 1'b0);
      step(1'b1, 32'h0044_1800, 32'h4C, 32'h3, 32'h4, 1'b1);
      check("fl.stall",  obs_stall_a,   1'b0);
      check("fl.bubble", a_ex_valid,    1'b0);
      check("fl.count",  a_stall_count, 16'd1);

      // R-type writing r0, then an illegal opcode
      step(1'b1, 32'h0044_0000, 32'h50, 32'hA, 32'hB, 1'b0);
      check("r0.reg_write", a_ex_reg_write, 1'b0);
      step(1'b1, 32'hFC00_0000, 32'h54, 32'hA, 32'hB, 1'b0);
      check("ill.illegal",   a_ex_illegal,   1'b1);
      check("ill.valid",     a_ex_valid,     1'b1);
      check("ill.mem_read",  a_ex_mem_read,  1'b0);
      check("ill.reg_write", a_ex_reg_write, 1'b0);

      // 16-bit build: pc 0xFFFC, imm +1 wraps to 0x0004 (rs_data == rt_data)
      step(1'b1, 32'h1000_0001, 32'h0000_FFFC, 32'h3, 32'h3, 1'b0);
      check("w16.taken",  obs_bt_b,  1'b1);
      check("w16.target", obs_tgt_b, 16'h0004);

      // reset mid-stream while a load sits in EX
      step(1'b1, 32'h8C22_0008, 32'h60, 32'h1, 32'h2, 1'b0);
      reset_mid(32'h0044_1800);
      step(1'b1, 32'h0044_1800, 32'h64, 32'h3, 32'h4, 1'b0);
      check("rst.issue", a_ex_valid, 1'b1);

      // random traffic on a small register set so hazards are frequent
      ins = '0; pc = '0;
      for (int i = 0; i < 600; i++) begin
         if (!last_stall) begin
            r  = $urandom();
            case ($urandom_range(0, 5))
               0:       op = 6'd0;
               1, 5:    op = 6'd35;
               2:       op = 6'd43;
               3:       op = 6'd4;
               default: begin
                  op = 6'($urandom());
                  if (op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4) op = 6'h3F;
               end
            endcase
            ins = {op, 3'b000, r[17:16], 3'b000, r[19:18], r[15:0]};
            pc  = $urandom() & 32'hFFFF_FFFC;
            v   = ($urandom_range(0, 7) != 0);
         end else begin
            v   = 1'b1;
         end
         fl   = ($urandom_range(0, 9) == 0);
         rs_d = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
         rt_d = ($urandom_range(0, 2) == 0) ? rs_d : $urandom();
         step(v, ins, pc, rs_d, rt_d, fl);
         if ($urandom_range(0, 99) == 0) reset_mid(ins);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
